// File: rtl/sn_pkg.sv
// Shared constants and types for the stochastic-core result framer.
package sn_pkg;
  localparam int DATA_W        = 9;
  localparam int NUM_CH        = 3;
  localparam int GAP_CYCLES    = 2;
  localparam int ID_W          = 2;
  localparam int SUBFRAME_BITS = 1 + ID_W + DATA_W + 1 + 1;

  localparam logic [1:0] CH_MUL  = 2'd0;
  localparam logic [1:0] CH_ADD  = 2'd1;
  localparam logic [1:0] CH_SMUL = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ID     = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    GAP    = 3'd6
  } framer_state_e;
endpackage

// File: rtl/sn_result_framer_if.sv
// Result inputs and framed serial outputs between the stochastic core and the framer.
interface sn_result_framer_if #(
  parameter int DATA_W = sn_pkg::DATA_W
);
  logic              epoch_done;
  logic [DATA_W-1:0] res_mul;
  logic [DATA_W-1:0] res_add;
  logic [DATA_W-1:0] res_smul;
  logic              ovr_clr;
  logic              ser_out;
  logic              frame_sync;
  logic              busy;
  logic              overrun;

  modport master (
    output epoch_done, res_mul, res_add, res_smul, ovr_clr,
    input  ser_out, frame_sync, busy, overrun
  );

  modport slave (
    input  epoch_done, res_mul, res_add, res_smul, ovr_clr,
    output ser_out, frame_sync, busy, overrun
  );
endinterface

// File: rtl/sn_word_serializer.sv
// Holds one channel's ID and data word, shifts them out LSB-first (ID first)
// and keeps the even parity of the data word ready for the PARITY bit.
module sn_word_serializer
  import sn_pkg::*;
#(
  parameter int DATA_W = sn_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [ID_W-1:0]   id_i,
  output logic              bit_o,
  output logic              parity_o
);
  localparam int SH_W = DATA_W + ID_W;

  logic [SH_W-1:0] sh_q;
  logic            par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      par_q <= 1'b0;
    end else if (load_i) begin
      sh_q  <= {word_i, id_i};
      par_q <= ^word_i;
    end else if (shift_i) begin
      sh_q  <= {1'b0, sh_q[SH_W-1:1]};
    end
  end

  assign bit_o    = sh_q[0];
  assign parity_o = par_q;
endmodule

// File: rtl/sn_result_framer.sv
// Captures the three averaged results at epoch close and sends them as one
// framed serial packet (START, ID, DATA, PARITY, STOP per channel, then a gap).
module sn_result_framer #(
  parameter int DATA_W     = sn_pkg::DATA_W,
  parameter int NUM_CH     = sn_pkg::NUM_CH,
  parameter int GAP_CYCLES = sn_pkg::GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  sn_result_framer_if.slave  bus
);
  import sn_pkg::*;

  localparam logic [3:0] ID_LAST   = 4'(ID_W - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [1:0] CH_LAST   = 2'(NUM_CH - 1);

  framer_state_e     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        ch_q, ch_d;
  logic [DATA_W-1:0] snap_q [NUM_CH];
  logic              ser_out_q, ser_out_d;
  logic              fsync_q, fsync_d;
  logic              busy_q;
  logic              ovr_q, ovr_d;

  logic              busy_now, capture;
  logic              ser_load, ser_shift, ser_bit, ser_par;
  logic [DATA_W-1:0] load_word;

  assign busy_now = (state_q != IDLE);
  assign capture  = bus.epoch_done && !busy_now;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (bus.epoch_done) begin
          state_d = START;
          cnt_d   = '0;
          ch_d    = CH_MUL;
        end
      end
      START: begin
        state_d = ID;
        cnt_d   = '0;
      end
      ID: begin
        if (cnt_q == ID_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
        cnt_d = '0;
        if (ch_q != CH_LAST) begin
          state_d = START;
          ch_d    = ch_q + 2'd1;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The first channel loads straight from the inputs because the snapshot
  // registers only update on the same edge.
  assign ser_load  = (state_d == START);
  assign ser_shift = (state_d == ID) || (state_d == DATA);
  assign load_word = capture ? bus.res_mul : snap_q[ch_d];

  sn_word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ser_load),
    .shift_i  (ser_shift),
    .word_i   (load_word),
    .id_i     (ch_d),
    .bit_o    (ser_bit),
    .parity_o (ser_par)
  );

  // Outputs are decoded from the next state so the registered pin shows the
  // bit of the state being entered.
  always_comb begin
    ser_out_d = 1'b0;
    case (state_d)
      START:    ser_out_d = 1'b1;
      ID, DATA: ser_out_d = ser_bit;
      PARITY:   ser_out_d = ser_par;
      default:  ser_out_d = 1'b0;
    endcase
  end

  assign fsync_d = (state_d == START) && (ch_d == CH_MUL);
  assign ovr_d   = (bus.epoch_done && busy_now) ? 1'b1 :
                   (bus.ovr_clr ? 1'b0 : ovr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      ser_out_q <= 1'b0;
      fsync_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      ser_out_q <= ser_out_d;
      fsync_q   <= fsync_d;
      busy_q    <= (state_d != IDLE);
      ovr_q     <= ovr_d;
      if (capture) begin
        snap_q[CH_MUL]  <= bus.res_mul;
        snap_q[CH_ADD]  <= bus.res_add;
        snap_q[CH_SMUL] <= bus.res_smul;
      end
    end
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.frame_sync = fsync_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sn_result_framer.sv
// Self-checking bench for sn_result_framer: packet contents come from a
// bit-list model built from the framing rules.
module tb_sn_result_framer;
  import sn_pkg::*;

  localparam int PKT_LEN = NUM_CH * SUBFRAME_BITS + GAP_CYCLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sn_result_framer_if #(.DATA_W(DATA_W)) bus();

  sn_result_framer #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_bits [PKT_LEN];
  logic got_bits [PKT_LEN];

  typedef struct {
    logic [8:0] mul;
    logic [8:0] add;
    logic [8:0] smul;
    logic [2:0] par;   // {smul, add, mul} expected parity bits
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected line activity: per channel a 1, the channel number LSB first,
  // the word LSB first, a bit making the data's one-count even, a 0; then idle gap.
  task automatic build_model(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s);
    logic [8:0] w [3];
    int p;
    w[0] = m; w[1] = a; w[2] = s;
    p = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_bits[p] = 1'b1;             p = p + 1;
      exp_bits[p] = 1'(ch % 2);       p = p + 1;
      exp_bits[p] = 1'((ch / 2) % 2); p = p + 1;
      for (int b = 0; b < 9; b++) begin
        exp_bits[p] = w[ch][b];       p = p + 1;
      end
      exp_bits[p] = 1'($countones(w[ch]) % 2); p = p + 1;
      exp_bits[p] = 1'b0;             p = p + 1;
    end
    for (int g = 0; g < GAP_CYCLES; g++) begin
      exp_bits[p] = 1'b0;             p = p + 1;
    end
  endtask

  task automatic pulse_epoch(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s);
    @(posedge clk); #1;
    bus.res_mul = m; bus.res_add = a; bus.res_smul = s;
    bus.epoch_done = 1'b1;
    @(posedge clk); #1;
    bus.epoch_done = 1'b0;
  endtask

  // Called right after pulse_epoch; walks the whole packet and the cycle after it.
  task automatic check_packet(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s,
                              input string tag);
    build_model(m, a, s);
    for (int i = 0; i < PKT_LEN; i++) begin
      @(negedge clk);
      got_bits[i] = bus.ser_out;
      chk($sformatf("%s_bit%0d", tag, i), 32'(bus.ser_out), 32'(exp_bits[i]));
      chk($sformatf("%s_fsync%0d", tag, i), 32'(bus.frame_sync), 32'(i == 0));
      chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ser_end"}, 32'(bus.ser_out), 32'd0);
  endtask

  task automatic clear_overrun();
    @(posedge clk); #1 bus.ovr_clr = 1'b1;
    @(posedge clk); #1 bus.ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rm, ra, rs;
    bus.epoch_done = 1'b0;
    bus.ovr_clr    = 1'b0;
    bus.res_mul    = '0;
    bus.res_add    = '0;
    bus.res_smul   = '0;

    tbl[0] = '{mul: 9'h0A5, add: 9'h1FF, smul: 9'h100, par: 3'b110};
    tbl[1] = '{mul: 9'h000, add: 9'h000, smul: 9'h000, par: 3'b000};
    tbl[2] = '{mul: 9'h001, add: 9'h003, smul: 9'h007, par: 3'b101};
    tbl[3] = '{mul: 9'h155, add: 9'h0AA, smul: 9'h1FE, par: 3'b001};

    // Reset state, then a long idle stretch
    #12;
    chk("rst_ser", 32'(bus.ser_out), 32'd0);
    chk("rst_fsync", 32'(bus.frame_sync), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_ser", 32'(bus.ser_out), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_fsync", 32'(bus.frame_sync), 32'd0);
    end

    // Table-driven packets with hand-derived parity bits
    for (int v = 0; v < 4; v++) begin
      pulse_epoch(tbl[v].mul, tbl[v].add, tbl[v].smul);
      check_packet(tbl[v].mul, tbl[v].add, tbl[v].smul, $sformatf("tbl%0d", v));
      for (int ch = 0; ch < NUM_CH; ch++)
        chk($sformatf("tbl%0d_par%0d", v, ch), 32'(got_bits[ch * SUBFRAME_BITS + 12]),
            32'(tbl[v].par[ch]));
      chk($sformatf("tbl%0d_ovr", v), 32'(bus.overrun), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Snapshot held while inputs change after capture
    pulse_epoch(9'h0A5, 9'h1FF, 9'h100);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 bus.res_mul = '0; bus.res_add = '0; bus.res_smul = '0;
      end
    join_none
    check_packet(9'h0A5, 9'h1FF, 9'h100, "snap");

    // epoch_done mid-packet: ignored, overrun set, no follow-on packet
    pulse_epoch(9'h123, 9'h045, 9'h1C3);
    fork
      begin
        repeat (10) @(posedge clk);
        #1 bus.epoch_done = 1'b1;
        bus.res_mul = 9'h011; bus.res_add = 9'h0F0; bus.res_smul = 9'h18C;
        @(posedge clk);
        #1 bus.epoch_done = 1'b0;
      end
    join_none
    check_packet(9'h123, 9'h045, 9'h1C3, "ovr");
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    repeat (10) @(negedge clk);
    chk("ovr_no_new_pkt", 32'(bus.busy), 32'd0);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    clear_overrun();
    pulse_epoch(9'h011, 9'h0F0, 9'h18C);
    check_packet(9'h011, 9'h0F0, 9'h18C, "after_ovr");

    // ovr_clr and an overrun event in the same cycle: set wins
    pulse_epoch(9'h0C3, 9'h03C, 9'h1AA);
    fork
      begin
        repeat (5) @(posedge clk);
        #1 bus.epoch_done = 1'b1; bus.ovr_clr = 1'b1;
        @(posedge clk);
        #1 bus.epoch_done = 1'b0; bus.ovr_clr = 1'b0;
      end
    join_none
    check_packet(9'h0C3, 9'h03C, 9'h1AA, "setwins");
    chk("setwins_ovr", 32'(bus.overrun), 32'd1);
    clear_overrun();

    // Asynchronous reset in the middle of ch1 data
    pulse_epoch(9'h0A5, 9'h1FF, 9'h100);
    repeat (20) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_ser", 32'(bus.ser_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ser", 32'(bus.ser_out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_fsync", 32'(bus.frame_sync), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", 32'(bus.busy), 32'd0);
    pulse_epoch(9'h0A5, 9'h1FF, 9'h100);
    check_packet(9'h0A5, 9'h1FF, 9'h100, "post_rst");

    // epoch_done during the last GAP cycle is rejected
    chk("gap_pre_ovr", 32'(bus.overrun), 32'd0);
    pulse_epoch(9'h1E1, 9'h01E, 9'h099);
    fork
      begin
        repeat (PKT_LEN - 1) @(posedge clk);
        #1 bus.epoch_done = 1'b1;
        @(posedge clk);
        #1 bus.epoch_done = 1'b0;
      end
    join_none
    check_packet(9'h1E1, 9'h01E, 9'h099, "gap");
    chk("gap_ovr", 32'(bus.overrun), 32'd1);
    repeat (5) @(negedge clk);
    chk("gap_no_pkt", 32'(bus.busy), 32'd0);
    clear_overrun();

    // Randomized packets against the model
    for (int r = 0; r < 6; r++) begin
      rm = 9'($urandom); ra = 9'($urandom); rs = 9'($urandom);
      pulse_epoch(rm, ra, rs);
      check_packet(rm, ra, rs, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_ovr", r), 32'(bus.overrun), 32'd0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
